fila_reader: RTL and testbench

- Consumer-side controller for the team's 8-entry, 8-bit queue block.
- Watches the queue length and issues correctly timed single-cycle dequeue requests.
- Captures the word the queue presents one cycle later and holds it on a valid/ready output port for downstream logic (display/serial stage).
- Guards against the queue's enqueue-over-dequeue priority by aborting and backing off.

---
 rtl/fila_reader.sv | 74 +++++++
 tb/tb_fila_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_reader.sv
// Consumer side of the 8-entry queue: issues dequeue pulses timed to the queue's
// sampling window and holds each fetched word on a valid/ready port.
module fila_reader #(
  parameter int RETRY_GAP = 3
) (
  input  logic       clock_10KHz,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [2:0] len_in,
  input  logic       enq_busy_in,
  input  logic [7:0] q_data_in,
  output logic       deq_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic [7:0] count_out
);

  localparam int GW = $clog2(RETRY_GAP + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, HOLD, BACKOFF} state_t;

  state_t        state;
  logic [GW-1:0] gap;

  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      deq_out   <= 1'b0;
      data_out  <= 8'd0;
      valid_out <= 1'b0;
      count_out <= 8'd0;
      gap       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_in && len_in != 3'd0 && !enq_busy_in) begin
            state   <= REQ;
            deq_out <= 1'b1;
          end
        end
        REQ: begin
          // the queue samples our pulse at this edge; a simultaneous enqueue steals it
          deq_out <= 1'b0;
          if (enq_busy_in) begin
            state <= BACKOFF;
            gap   <= GW'(RETRY_GAP - 1);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: state <= CAPT;
        CAPT: begin
          data_out  <= q_data_in;
          valid_out <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            count_out <= count_out + 8'd1;
            state     <= IDLE;
          end
        end
        BACKOFF: begin
          if (gap == '0) state <= IDLE;
          else           gap   <= gap - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fila_reader.sv
// Bench for fila_reader: a behavioural queue drives the reader; a cycle-level
// timeline model and a word scoreboard check every output on every cycle.
module tb_fila_reader;
  localparam int RETRY_GAP = 3;

  logic       clock_10KHz, reset, enable_in, enq_busy_in, ready_in;
  logic [2:0] len_in;
  logic [7:0] q_data_in;
  logic       deq_out, valid_out;
  logic [7:0] data_out, count_out;

  fila_reader #(.RETRY_GAP(RETRY_GAP)) dut (
    .clock_10KHz(clock_10KHz), .reset(reset), .enable_in(enable_in),
    .len_in(len_in), .enq_busy_in(enq_busy_in), .q_data_in(q_data_in),
    .deq_out(deq_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .count_out(count_out)
  );

  initial clock_10KHz = 1'b0;
  always #50 clock_10KHz = ~clock_10KHz;

  int tests = 0, fails = 0;

  // queue model
  logic [7:0] qm[$];
  int         qbusy;
  logic [7:0] qpend;
  logic [7:0] cur_w;
  logic       deq_s;

  // scoreboard and timeline model
  logic [7:0] expq[$];
  int  exp_count;
  bit  free, exp_valid;
  int  n, deq_cyc, valid_at, free_at, aborts;
  bit  p_en, p_enq, p_ready;
  logic [2:0] p_len;

  // stimulus knobs
  int  enq_pct, ready_pct, en_pct;
  bit  force_collide, rand_words;
  logic [7:0] push_list[$];

  // DUT-side logs for literal checks
  int         deq_log[$];
  logic [7:0] dut_deliv[$];
  int         dut_valid_first;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  task automatic clear_logs();
    deq_log.delete();
    dut_deliv.delete();
    dut_valid_first = -1;
    aborts = 0;
  endtask

  task automatic model_reset();
    qm.delete(); expq.delete();
    qbusy = 0; exp_count = 0; free = 1; exp_valid = 0;
    deq_cyc = -100; valid_at = -1; free_at = -1;
    p_en = 0; p_enq = 0; p_ready = 0; p_len = 0;
    len_in = 0; q_data_in = 0; enable_in = 0; enq_busy_in = 0; ready_in = 0;
  endtask

  task automatic cycle();
    bit e_deq, can, enq;
    logic [7:0] tmp;
    @(negedge clock_10KHz);
    n++;
    e_deq = free && p_en && (p_len != 3'd0) && !p_enq;
    if (n == deq_cyc + 1) begin
      if (p_enq) begin free_at = n + RETRY_GAP; aborts++; end
      else valid_at = deq_cyc + 3;
    end
    if (exp_valid && p_ready) begin
      exp_valid = 0; free = 1; exp_count = (exp_count + 1) % 256;
      if (expq.size() > 0) tmp = expq.pop_front();
    end
    if (n == valid_at) exp_valid = 1;
    if (n == free_at) free = 1;
    if (e_deq) begin free = 0; deq_cyc = n; end

    check("deq_out", int'(deq_out), int'(e_deq));
    check("valid_out", int'(valid_out), int'(exp_valid));
    check("count_out", int'(count_out), exp_count);
    if (exp_valid) begin
      if (expq.size() > 0) check("data_out", int'(data_out), int'(expq[0]));
      else check("scoreboard_empty", 1, 0);
    end

    deq_s = deq_out;
    if (deq_out) deq_log.push_back(n);
    if (valid_out && dut_valid_first < 0) dut_valid_first = n;

    // drive inputs for the coming edge
    can = (qbusy == 0) && (qm.size() < 7);
    enq = 0;
    if (force_collide && e_deq && can) begin
      enq = 1; force_collide = 0;
      cur_w = (push_list.size() > 0) ? push_list.pop_front() : 8'($urandom);
    end else if (can && $urandom_range(99) < enq_pct) begin
      if (push_list.size() > 0) begin enq = 1; cur_w = push_list.pop_front(); end
      else if (rand_words) begin enq = 1; cur_w = 8'($urandom); end
    end
    enable_in   = ($urandom_range(99) < en_pct);
    ready_in    = ($urandom_range(99) < ready_pct);
    enq_busy_in = enq;
    if (valid_out && ready_in) dut_deliv.push_back(data_out);
    p_en = enable_in; p_enq = enq; p_ready = ready_in; p_len = len_in;

    @(posedge clock_10KHz);
    #1;
    begin
      bit idle_now;
      idle_now = (qbusy == 0);
      if (qbusy == 2) begin q_data_in = qpend; qbusy = 1; end
      else if (qbusy == 1) qbusy = 0;
      if (idle_now && deq_s && !enq && qm.size() > 0) begin
        qpend = qm.pop_front(); qbusy = 2;
      end
      if (enq) begin qm.push_back(cur_w); expq.push_back(cur_w); end
      len_in = 3'(qm.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_deq", int'(deq_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_count", int'(count_out), 0);
    check("rst_data", int'(data_out), 0);
    @(posedge clock_10KHz);
    @(posedge clock_10KHz);
    @(negedge clock_10KHz);
    reset = 1'b0;
  endtask

  task automatic preload();
    en_pct = 0; enq_pct = 100;
    for (int i = 0; i < 40 && (push_list.size() > 0 || qbusy != 0); i++) cycle();
    if (push_list.size() > 0) check("preload_timeout", 1, 0);
    enq_pct = 0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    n = 0; force_collide = 0; rand_words = 0;
    enq_pct = 0; ready_pct = 0; en_pct = 0;
    do_reset();

    // idle with an empty queue
    clear_logs(); en_pct = 100; ready_pct = 100;
    run(20);
    check("idle_no_deq", deq_log.size(), 0);
    check("idle_data", int'(data_out), 0);

    // single read
    push_list.push_back(8'hA5); preload(); clear_logs();
    en_pct = 100; ready_pct = 100;
    run(14);
    check("single_pulses", deq_log.size(), 1);
    if (deq_log.size() > 0) check("single_latency", dut_valid_first - deq_log[0], 3);
    check("single_words", dut_deliv.size(), 1);
    if (dut_deliv.size() > 0) check("single_word", int'(dut_deliv[0]), 8'hA5);
    check("single_count", int'(count_out), 1);

    // burst drain 01..07
    for (int i = 1; i <= 7; i++) push_list.push_back(8'(i));
    preload(); clear_logs();
    en_pct = 100; ready_pct = 100;
    run(45);
    check("burst_pulses", deq_log.size(), 7);
    for (int i = 1; i < deq_log.size(); i++) check("burst_gap", deq_log[i] - deq_log[i-1], 5);
    check("burst_words", dut_deliv.size(), 7);
    for (int i = 0; i < dut_deliv.size(); i++) check("burst_order", int'(dut_deliv[i]), i + 1);
    check("burst_count", int'(count_out), 8);
    check("burst_len", int'(len_in), 0);

    // backpressure
    push_list.push_back(8'h3C); push_list.push_back(8'hC3);
    preload(); clear_logs();
    en_pct = 100; ready_pct = 0;
    for (int i = 0; i < 20 && dut_valid_first < 0; i++) cycle();
    run(10);
    check("bp_pulses", deq_log.size(), 1);
    check("bp_hold", int'(data_out), 8'h3C);
    check("bp_valid", int'(valid_out), 1);
    ready_pct = 100;
    run(15);
    check("bp_words", dut_deliv.size(), 2);
    if (dut_deliv.size() == 2) begin
      check("bp_first", int'(dut_deliv[0]), 8'h3C);
      check("bp_second", int'(dut_deliv[1]), 8'hC3);
    end

    // collision at the edge ending REQ
    push_list.push_back(8'h5A); preload(); clear_logs();
    push_list.push_back(8'h66); force_collide = 1;
    en_pct = 100; ready_pct = 100;
    run(25);
    check("col_aborts", aborts, 1);
    check("col_pulses", deq_log.size(), 3);
    if (deq_log.size() > 1)
      check("col_backoff", int'(deq_log[1] - deq_log[0] >= RETRY_GAP + 1), 1);
    check("col_words", dut_deliv.size(), 2);
    if (dut_deliv.size() == 2) begin
      check("col_first", int'(dut_deliv[0]), 8'h5A);
      check("col_second", int'(dut_deliv[1]), 8'h66);
    end
    check("col_count", int'(count_out), 12);

    // reset asserted while in WAIT
    push_list.push_back(8'h11); push_list.push_back(8'h22); preload(); clear_logs();
    en_pct = 100; ready_pct = 100;
    for (int i = 0; i < 30 && deq_log.size() < 2; i++) cycle();
    check("wait_reached", deq_log.size(), 2);
    check("wait_not_aborted", int'(p_enq), 0);
    #2;
    do_reset();
    clear_logs();
    push_list.push_back(8'h77); preload(); clear_logs();
    en_pct = 100; ready_pct = 100;
    run(14);
    check("post_rst_words", dut_deliv.size(), 1);
    if (dut_deliv.size() > 0) check("post_rst_word", int'(dut_deliv[0]), 8'h77);
    check("post_rst_count", int'(count_out), 1);

    // randomized traffic, long enough for count_out to wrap
    rand_words = 1; enq_pct = 60; ready_pct = 75; en_pct = 92;
    run(4000);
    rand_words = 0; enq_pct = 0; ready_pct = 100; en_pct = 100;
    run(60);
    check("drain_len", int'(len_in), 0);
    check("drain_valid", int'(valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
